seg7_scan_ctrl: RTL and testbench

- Display stage directly downstream of the 8-bit register/store block (dff_mod).
- Captures the 8-bit data word it produces, plus an 8-bit tag (register index), into a 16-bit display register on a load strobe.
- Time-multiplexes the four hex digits onto a common-anode 4-digit 7-segment display, with a one-cycle anti-ghost blank between digits.
- Digit 3 supports optional leading-zero blanking.

---
 rtl/seg7_scan_ctrl.sv | 94 +++++++++
 tb/tb_seg7_scan_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode 7-segment scanner. It shows {tag, data} as four hex digits,
// with a one-cycle blank between digits and optional leading-zero blanking on digit 3.
module seg7_scan_ctrl #(
  parameter int REFRESH_DIV = 50000,
  parameter int DIV_WIDTH   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] d_in,
  input  logic [7:0] tag_in,
  input  logic       load,
  input  logic       blank_lz,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(REFRESH_DIV - 1);

  logic [15:0]          disp_reg;
  logic [DIV_WIDTH-1:0] prescaler;
  logic [1:0]           scan_idx;
  logic                 blank_q;
  logic                 tick;

  logic [3:0] nibble;
  logic [3:0] an_next;
  logic [6:0] seg_next;
  logic       dp_next;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0:    return 7'b1000000;
      4'h1:    return 7'b1111001;
      4'h2:    return 7'b0100100;
      4'h3:    return 7'b0110000;
      4'h4:    return 7'b0011001;
      4'h5:    return 7'b0010010;
      4'h6:    return 7'b0000010;
      4'h7:    return 7'b1111000;
      4'h8:    return 7'b0000000;
      4'h9:    return 7'b0010000;
      4'hA:    return 7'b0001000;
      4'hB:    return 7'b0000011;
      4'hC:    return 7'b1000110;
      4'hD:    return 7'b0100001;
      4'hE:    return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  assign tick   = (prescaler == DIV_LAST);
  assign nibble = disp_reg[{scan_idx, 2'b00} +: 4];

  // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    an_next  = 4'b1111;
    seg_next = 7'b1111111;
    dp_next  = 1'b1;
    if (!blank_q) begin
      an_next  = ~(4'b0001 << scan_idx);
      seg_next = hex_to_seg(nibble);
      dp_next  = (scan_idx != 2'd2);
      if (scan_idx == 2'd3 && blank_lz && nibble == 4'h0)
        seg_next = 7'b1111111;
    end
  end

  // NOTE: state uses non-blocking assignments, so each register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_reg  <= 16'h0000;
      prescaler <= '0;
      scan_idx  <= 2'd0;
      blank_q   <= 1'b0;
      an        <= 4'b1111;
      seg       <= 7'b1111111;
      dp        <= 1'b1;
    end else begin
      if (load)
        disp_reg <= {tag_in, d_in};
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick)
        scan_idx <= scan_idx + 2'd1;
      // The digit change and the blank gap are both triggered by tick, so the new digit appears after exactly one dark cycle.
      blank_q <= tick;
      an      <= an_next;
      seg     <= seg_next;
      dp      <= dp_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with REFRESH_DIV=4.
// Outputs are sampled 1 time unit after each rising edge.
module tb_seg7_scan_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] d_in;
  logic [7:0] tag_in;
  logic       load;
  logic       blank_lz;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [6:0] BLK = 7'b1111111;

  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Expected outputs on edges 2..18 after reset release, for disp_reg = 16'h02A3 captured at edge 2.
  logic [3:0] scan_an  [17] = '{
    4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1101, 4'b1101, 4'b1101, 4'b1111,
    4'b1011, 4'b1011, 4'b1011, 4'b1111, 4'b0111, 4'b0111, 4'b0111, 4'b1111, 4'b1110
  };
  logic [6:0] scan_seg [17] = '{
    7'b1000000, 7'b0110000, 7'b0110000, BLK, 7'b0001000, 7'b0001000, 7'b0001000, BLK,
    7'b0100100, 7'b0100100, 7'b0100100, BLK, 7'b1000000, 7'b1000000, 7'b1000000, BLK, 7'b0110000
  };
  logic       scan_dp  [17] = '{
    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1
  };

  seg7_scan_ctrl #(.REFRESH_DIV(4), .DIV_WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .d_in     (d_in),
    .tag_in   (tag_in),
    .load     (load),
    .blank_lz (blank_lz),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] observed, input logic [6:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e, input logic dp_e);
    check({tag, ".an"}, {3'b000, an}, {3'b000, an_e});
    check({tag, ".seg"}, seg, seg_e);
    check({tag, ".dp"}, {6'b0, dp}, {6'b0, dp_e});
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; d_in = 8'h00; tag_in = 8'h00; load = 1'b0; blank_lz = 1'b0;

    // Held in reset for three clocks.
    for (int i = 0; i < 3; i++) begin
      step();
      check_out($sformatf("reset_hold%0d", i), 4'b1111, BLK, 1'b1);
    end
    rst = 1'b1;
    step();
    check_out("release_edge1", 4'b1110, 7'b1000000, 1'b1);

    // One-cycle load of 02/A3, then a full scan cycle with wrap back to digit 0.
    tag_in = 8'h02; d_in = 8'hA3; load = 1'b1;
    for (int k = 0; k < 17; k++) begin
      step();
      load = 1'b0;
      check_out($sformatf("scan_edge%0d", k + 2), scan_an[k], scan_seg[k], scan_dp[k]);
    end

    // Leading-zero blanking on digit 3 with tag 01 / data 15.
    tag_in = 8'h01; d_in = 8'h15; load = 1'b1; blank_lz = 1'b1;
    step();
    load = 1'b0;
    step(10);
    check_out("lz_gap_edge29", 4'b1111, BLK, 1'b1);
    step();
    check_out("lz_blank_digit3", 4'b0111, BLK, 1'b1);
    blank_lz = 1'b0;
    step();
    check_out("lz_off_digit3", 4'b0111, 7'b1000000, 1'b1);

    // Load 87 in the tick cycle while digit 3 is scanned.
    d_in = 8'h87; load = 1'b1;
    step();
    load = 1'b0;
    check_out("coinc_digit3", 4'b0111, 7'b1000000, 1'b1);
    step();
    check_out("coinc_gap", 4'b1111, BLK, 1'b1);
    step();
    check_out("coinc_digit0_a", 4'b1110, 7'b1111000, 1'b1);
    step();
    check_out("coinc_digit0_b", 4'b1110, 7'b1111000, 1'b1);
    step(3);
    check_out("coinc_digit1", 4'b1101, 7'b0000000, 1'b1);
    step(4);
    check_out("pre_reset_digit2", 4'b1011, 7'b1111001, 1'b0);

    // Asynchronous reset in the middle of the clock period.
    #2;
    rst = 1'b0;
    #1;
    check_out("async_reset", 4'b1111, BLK, 1'b1);
    step();
    rst = 1'b1;
    step();
    check_out("rerelease_edge1", 4'b1110, 7'b1000000, 1'b1);
    step(3);
    check_out("rerelease_edge4", 4'b1110, 7'b1000000, 1'b1);
    step();
    check_out("rerelease_gap", 4'b1111, BLK, 1'b1);

    // Decode sweep: data 00..FF in steps of 11; digits 0 and 1 show the same nibble.
    for (int i = 0; i < 16; i++) begin
      rst = 1'b0; tag_in = 8'h00; d_in = 8'(i * 17); load = 1'b1;
      step();
      rst = 1'b1;
      step(2);
      check_out($sformatf("sweep_d0_%h", i), 4'b1110, hex_tab[i], 1'b1);
      step(4);
      check_out($sformatf("sweep_d1_%h", i), 4'b1101, hex_tab[i], 1'b1);
    end
    load = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
